// File: rtl/data_mem_responder_if.sv
// Host and core bus bundle for data_mem_responder.
// Optional macro: DATA_MEM_COLLISION_FLAG_EN adds the sticky 'collision' flag.
// The slave modport is the responder side; the master modport is the host/core side.
interface data_mem_responder_if #(
    parameter int CORES      = 2,
    parameter int WIDTH      = 12,
    parameter int ADDR_WIDTH = 12
);
    // Job control, sampled by the responder in IDLE only
    logic                          go;
    logic [ADDR_WIDTH-1:0]         loadLen;
    logic [ADDR_WIDTH-1:0]         outBase;
    logic [ADDR_WIDTH-1:0]         outLen;

    // Host load stream
    logic [WIDTH-1:0]              inData;
    logic                          inValid;
    logic                          inReady;

    // Host unload stream
    logic [WIDTH-1:0]              outData;
    logic                          outValid;
    logic                          outReady;

    // Core side
    logic [CORES-1:0]              coreStart;
    logic [CORES-1:0]              coreDone;
    logic [CORES*ADDR_WIDTH-1:0]   coreAddr;
    logic [CORES-1:0]              coreWrEn;
    logic [CORES*WIDTH-1:0]        coreWrData;
    logic [CORES*WIDTH-1:0]        coreRdData;

    logic                          jobDone;
`ifdef DATA_MEM_COLLISION_FLAG_EN
    logic                          collision;
`endif

    modport slave (
`ifdef DATA_MEM_COLLISION_FLAG_EN
        output collision,
`endif
        input  go, loadLen, outBase, outLen,
        input  inData, inValid,
        output inReady,
        output outData, outValid,
        input  outReady,
        output coreStart,
        input  coreDone, coreAddr, coreWrEn, coreWrData,
        output coreRdData,
        output jobDone
    );

    modport master (
`ifdef DATA_MEM_COLLISION_FLAG_EN
        input  collision,
`endif
        output go, loadLen, outBase, outLen,
        output inData, inValid,
        input  inReady,
        input  outData, outValid,
        output outReady,
        input  coreStart,
        output coreDone, coreAddr, coreWrEn, coreWrData,
        input  coreRdData,
        input  jobDone
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for a multicore array: owns the shared data RAM, serves
// every core port combinationally, and sequences LOAD -> RUN -> UNLOAD jobs.
// Optional macro: DATA_MEM_COLLISION_FLAG_EN adds a sticky same-address write flag.
//
// Stream handshakes (load and unload): a word moves on a rising edge where both
// valid and ready are high. inReady is high for the whole LOAD state; outValid is
// high for the whole UNLOAD state (unless outLen is 0), and outData does not change
// while outReady is low because the unload pointer only advances on a transfer.
module data_mem_responder #(
    parameter int CORES      = 2,
    parameter int WIDTH      = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                    clk,
    input  logic                    rstN,
    data_mem_responder_if.slave     bus,
    output logic [2:0]              dbgState
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        RUN    = 3'd3,
        UNLOAD = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

    state_t                 state;
    state_t                 nextState;

    logic [ADDR_WIDTH-1:0]  ptr;
    logic [ADDR_WIDTH-1:0]  loadLenQ;
    logic [ADDR_WIDTH-1:0]  outBaseQ;
    logic [ADDR_WIDTH-1:0]  outLenQ;
    logic [ADDR_WIDTH-1:0]  xferCnt;
    // Low in the first RUN cycle, high afterwards; gates the RUN exit
    logic                   runAged;

    logic [WIDTH-1:0]       mem [DEPTH];

    logic [ADDR_WIDTH-1:0]  cAddr   [CORES];
    logic [WIDTH-1:0]       cWrData [CORES];

    logic                   loadWrite;
    logic                   loadLast;
    logic                   runExit;
    logic                   outValidInt;
    logic                   unloadXfer;
    logic                   unloadLast;

    function automatic logic inRange(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    // Unpack the flat core buses into per-core views
    always_comb begin
        for (int i = 0; i < CORES; i++) begin
            cAddr[i]   = bus.coreAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            cWrData[i] = bus.coreWrData[i*WIDTH +: WIDTH];
        end
    end

    // loadLen of zero gives a single LOAD cycle with no writes
    assign loadWrite   = (state == LOAD) && (loadLenQ != '0) && bus.inValid;
    assign loadLast    = (loadLenQ == '0) || (bus.inValid && (ptr == loadLenQ - ONE));
    assign runExit     = runAged && (&bus.coreDone);
    assign outValidInt = (state == UNLOAD) && (outLenQ != '0);
    assign unloadXfer  = outValidInt && bus.outReady;
    assign unloadLast  = (outLenQ == '0) || (unloadXfer && (xferCnt == outLenQ - ONE));

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state decode for the job sequence
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.go) nextState = LOAD;
            LOAD:    if (loadLast) nextState = START;
            START:   nextState = RUN;
            RUN:     if (runExit) nextState = UNLOAD;
            UNLOAD:  if (unloadLast) nextState = FIN;
            FIN:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs decoded from state and the unload pointer
    always_comb begin
        bus.inReady   = (state == LOAD);
        bus.outValid  = outValidInt;
        bus.coreStart = {CORES{state == START}};
        bus.jobDone   = (state == FIN);
        bus.outData   = inRange(ptr) ? mem[ptr] : '0;
        dbgState      = state;
    end

    // Pointer, job parameters and transfer counter
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ptr      <= '0;
            loadLenQ <= '0;
            outBaseQ <= '0;
            outLenQ  <= '0;
            xferCnt  <= '0;
            runAged  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        loadLenQ <= bus.loadLen;
                        outBaseQ <= bus.outBase;
                        outLenQ  <= bus.outLen;
                        ptr      <= '0;
                    end
                end
                LOAD: begin
                    if (loadWrite) ptr <= ptr + ONE;
                end
                START: begin
                    runAged <= 1'b0;
                end
                RUN: begin
                    runAged <= 1'b1;
                    if (runExit) begin
                        ptr     <= outBaseQ;
                        xferCnt <= '0;
                    end
                end
                UNLOAD: begin
                    if (unloadXfer) begin
                        ptr     <= ptr + ONE;
                        xferCnt <= xferCnt + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM writes: host stream in LOAD, cores in RUN. Cores are visited from the
    // highest index down so the lowest-index write to an address lands last.
    // No reset: contents survive a reset.
    always_ff @(posedge clk) begin
        if (loadWrite && inRange(ptr)) mem[ptr] <= bus.inData;
        if (state == RUN) begin
            for (int i = CORES - 1; i >= 0; i--) begin
                if (bus.coreWrEn[i] && inRange(cAddr[i])) mem[cAddr[i]] <= cWrData[i];
            end
        end
    end

    // Core reads: zero latency, old value on a same-cycle write, 0 when out of range
    always_comb begin
        bus.coreRdData = '0;
        for (int i = 0; i < CORES; i++) begin
            if (inRange(cAddr[i])) bus.coreRdData[i*WIDTH +: WIDTH] = mem[cAddr[i]];
        end
    end

`ifdef DATA_MEM_COLLISION_FLAG_EN
    logic collide;
    logic collisionQ;

    // Detect two or more in-range core writes to one address in the same cycle
    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < CORES; i++) begin
            for (int j = i + 1; j < CORES; j++) begin
                if (bus.coreWrEn[i] && bus.coreWrEn[j] &&
                    (cAddr[i] == cAddr[j]) && inRange(cAddr[i]))
                    collide = 1'b1;
            end
        end
    end

    // Sticky collision flag, cleared when a job is accepted
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)                          collisionQ <= 1'b0;
        else if (state == IDLE && bus.go)   collisionQ <= 1'b0;
        else if (state == RUN && collide)   collisionQ <= 1'b1;
    end

    assign bus.collision = collisionQ;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: load, core access, unload, reset mid-job.
module tb_data_mem_responder;
    localparam int CORES = 2;
    localparam int W     = 12;
    localparam int AW    = 12;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_UNLOAD = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

    logic       clk;
    logic       rstN;
    logic [2:0] dbgState;
    int         total;
    int         bad;
    logic [W-1:0] expQ[$];

    data_mem_responder_if #(.CORES(CORES), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    data_mem_responder #(.CORES(CORES), .WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(4096)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .bus      (bus),
        .dbgState (dbgState)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setCore(input int i, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.coreWrEn[i]            = we;
        bus.coreAddr[i*AW +: AW]   = a;
        bus.coreWrData[i*W +: W]   = d;
    endtask

    task automatic readCore(input int i, input logic [AW-1:0] a, output logic [W-1:0] d);
        bus.coreAddr[i*AW +: AW] = a;
        #1;
        d = bus.coreRdData[i*W +: W];
    endtask

    logic [W-1:0] rd;
    logic         inPat  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         outPat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        total = 0;
        bad   = 0;
        rstN  = 1'b0;
        bus.go = 1'b0; bus.loadLen = '0; bus.outBase = '0; bus.outLen = '0;
        bus.inData = '0; bus.inValid = 1'b0; bus.outReady = 1'b0;
        bus.coreDone = '0; bus.coreAddr = '0; bus.coreWrEn = '0; bus.coreWrData = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_state", 32'(dbgState), 32'(ST_IDLE));
        checkVal("rst_inReady", 32'(bus.inReady), 0);
        checkVal("rst_outValid", 32'(bus.outValid), 0);
        checkVal("rst_coreStart", 32'(bus.coreStart), 0);
        checkVal("rst_jobDone", 32'(bus.jobDone), 0);
`ifdef DATA_MEM_COLLISION_FLAG_EN
        checkVal("rst_collision", 32'(bus.collision), 0);
`endif
        stepCycle();
        rstN = 1'b1;
        stepCycle();

        // Test 1: load 1..4 with gaps
        bus.go = 1'b1; bus.loadLen = 12'd4; bus.outBase = 12'd0; bus.outLen = 12'd3;
        stepCycle();
        bus.go = 1'b0;
        begin
            int w;
            w = 1;
            for (int k = 0; k < 6; k++) begin
                bus.inValid = inPat[k];
                bus.inData  = inPat[k] ? W'(w) : 12'hFFF;
                @(negedge clk);
                checkVal($sformatf("load_state_%0d", k), 32'(dbgState), 32'(ST_LOAD));
                checkVal($sformatf("load_inReady_%0d", k), 32'(bus.inReady), 1);
                stepCycle();
                if (inPat[k]) w++;
            end
        end
        bus.inValid = 1'b0;
        @(negedge clk);
        checkVal("start_state", 32'(dbgState), 32'(ST_START));
        checkVal("start_inReady", 32'(bus.inReady), 0);
        checkVal("start_coreStart", 32'(bus.coreStart), 32'h3);
        stepCycle();
        @(negedge clk);
        checkVal("run_state", 32'(dbgState), 32'(ST_RUN));
        checkVal("run_coreStart", 32'(bus.coreStart), 0);
        for (int a = 0; a < 4; a++) begin
            readCore(1, AW'(a), rd);
            checkVal($sformatf("loaded_mem_%0d", a), 32'(rd), 32'(a + 1));
        end

        // Test 2: core0 writes, core1 reads; same-cycle read sees old value
        stepCycle();
        setCore(0, 1'b1, 12'd10, 12'h055);
        setCore(1, 1'b0, 12'd10, 12'h000);
        stepCycle();
        setCore(0, 1'b1, 12'd10, 12'hABC);
        @(negedge clk);
        checkVal("rd_old_value", 32'(bus.coreRdData[W +: W]), 32'h055);
        stepCycle();
        setCore(0, 1'b0, 12'd10, 12'h000);
        @(negedge clk);
        checkVal("rd_after_write", 32'(bus.coreRdData[W +: W]), 32'hABC);
        checkVal("run_no_restart", 32'(bus.coreStart), 0);

        // Test 3: same-address writes, lowest core wins
        stepCycle();
        setCore(0, 1'b1, 12'd5, 12'h111);
        setCore(1, 1'b1, 12'd5, 12'h222);
        stepCycle();
        setCore(0, 1'b0, 12'd5, 12'h000);
        setCore(1, 1'b0, 12'd5, 12'h000);
        @(negedge clk);
        checkVal("collide_rd0", 32'(bus.coreRdData[0 +: W]), 32'h111);
        checkVal("collide_rd1", 32'(bus.coreRdData[W +: W]), 32'h111);
`ifdef DATA_MEM_COLLISION_FLAG_EN
        checkVal("collision_set", 32'(bus.collision), 1);
`endif

        // Test 5: core0 done early, core1 late; go ignored outside IDLE
        stepCycle();
        bus.coreDone = 2'b01;
        bus.go = 1'b1; bus.loadLen = 12'd7;
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            bus.go = 1'b0;
            @(negedge clk);
            checkVal($sformatf("wait_done_%0d", k), 32'(dbgState), 32'(ST_RUN));
        end
        stepCycle();
        bus.coreDone = 2'b11;
        stepCycle();
        bus.coreDone = 2'b00;

        // Test 4: unload 3 words with outReady 1,0,1,1
        expQ.push_back(12'd1);
        expQ.push_back(12'd2);
        expQ.push_back(12'd3);
        for (int k = 0; k < 4; k++) begin
            bus.outReady = outPat[k];
            @(negedge clk);
            checkVal($sformatf("unload_state_%0d", k), 32'(dbgState), 32'(ST_UNLOAD));
            checkVal($sformatf("unload_valid_%0d", k), 32'(bus.outValid), 1);
            checkVal($sformatf("unload_data_%0d", k), 32'(bus.outData), 32'(expQ[0]));
            stepCycle();
            if (outPat[k]) void'(expQ.pop_front());
        end
        bus.outReady = 1'b0;
        checkVal("unload_queue_empty", 32'(expQ.size()), 0);
        @(negedge clk);
        checkVal("fin_state", 32'(dbgState), 32'(ST_FIN));
        checkVal("fin_jobDone", 32'(bus.jobDone), 1);
        checkVal("fin_outValid", 32'(bus.outValid), 0);
`ifdef DATA_MEM_COLLISION_FLAG_EN
        checkVal("collision_sticky", 32'(bus.collision), 1);
`endif
        stepCycle();
        @(negedge clk);
        checkVal("idle_state", 32'(dbgState), 32'(ST_IDLE));
        checkVal("idle_jobDone", 32'(bus.jobDone), 0);

        // Test 6: reset after 2 words of a load
        stepCycle();
        bus.go = 1'b1; bus.loadLen = 12'd5; bus.outBase = 12'd0; bus.outLen = 12'd0;
        stepCycle();
        bus.go = 1'b0;
        bus.inValid = 1'b1; bus.inData = 12'h7A1;
        stepCycle();
        bus.inData = 12'h7A2;
        stepCycle();
        bus.inValid = 1'b0;
        rstN = 1'b0;
        #1;
        checkVal("midrst_state", 32'(dbgState), 32'(ST_IDLE));
        checkVal("midrst_inReady", 32'(bus.inReady), 0);
        stepCycle();
        rstN = 1'b1;
        readCore(0, 12'd0, rd);
        checkVal("partial_mem0", 32'(rd), 32'h7A1);
        readCore(0, 12'd1, rd);
        checkVal("partial_mem1", 32'(rd), 32'h7A2);
        readCore(0, 12'd2, rd);
        checkVal("partial_mem2", 32'(rd), 32'd3);

        // Empty job: loadLen=0, outLen=0, cores already done -> RUN still lasts 2 cycles
        stepCycle();
        bus.coreDone = 2'b11;
        bus.go = 1'b1; bus.loadLen = 12'd0; bus.outLen = 12'd0;
        stepCycle();
        bus.go = 1'b0;
        begin
            logic [2:0] seq [7] = '{ST_LOAD, ST_START, ST_RUN, ST_RUN, ST_UNLOAD, ST_FIN, ST_IDLE};
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                checkVal($sformatf("empty_state_%0d", k), 32'(dbgState), 32'(seq[k]));
                if (seq[k] == ST_UNLOAD)
                    checkVal("empty_outValid", 32'(bus.outValid), 0);
                if (seq[k] == ST_FIN)
                    checkVal("empty_jobDone", 32'(bus.jobDone), 1);
                stepCycle();
            end
        end
        bus.coreDone = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
